// File: rtl/calc_pkg.sv
// Shared calculator definitions.
// Key codes produced by keypad_scanner and consumed by control_unit, plus
// the keypad scanner FSM state encodings.
package calc_pkg;

  // Digits 0-9 encode as their own value; the operator and command keys
  // occupy the top of the 4-bit code space.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Keypad scanner FSM states.
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix pins plus the decoded key event.
//   row_in      keypad rows, active-low, asynchronous to clk
//   col_out     column drive, active-low, exactly one bit low
//   key_pressed one-cycle strobe per accepted press
//   key_code    code of the last accepted key
//   is_op       last key is + - * /
//   is_eq       last key is =
//   is_clr      last key is C
//   dbg_state   scanner FSM state (observation only)
// Handshake: key_pressed is a single-cycle valid with no ready; the consumer
// must take key_code and the flags in that cycle. They stay stable until
// the next strobe, so a late reader still sees the last key.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_pressed;
  logic [3:0] key_code;
  logic       is_op;
  logic       is_eq;
  logic       is_clr;
  logic [1:0] dbg_state;

  // master: the scanner itself
  modport master (
    input  row_in,
    output col_out, key_pressed, key_code, is_op, is_eq, is_clr, dbg_state
  );

  // slave: keypad/consumer side
  modport slave (
    output row_in,
    input  col_out, key_pressed, key_code, is_op, is_eq, is_clr, dbg_state
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk, rst  clock and asynchronous active-high reset
//   d_i       asynchronous input vector
//   q_o       synchronized output (resets to all ones: idle pulled-up rows)
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Drives one column low at a time, captures a low row pattern at the end of
// the column dwell, confirms it for DEBOUNCE_CNT samples, emits one event,
// then waits for DEBOUNCE_CNT clean released samples before rescanning.
//   clk    system clock
//   reset  asynchronous active-high reset
//   kp     keypad_scanner_if.master (rows in, columns and key event out)
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scanner_if.master   kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

  // Row/column to key code. The lowest-index low row wins when several
  // rows are low in the captured pattern.
  function automatic logic [3:0] key_decode(input logic [3:0] rows,
                                            input logic [1:0] col);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    case ({r, col})
      4'b00_00: key_decode = 4'h1;
      4'b00_01: key_decode = 4'h2;
      4'b00_10: key_decode = 4'h3;
      4'b00_11: key_decode = KEY_ADD;
      4'b01_00: key_decode = 4'h4;
      4'b01_01: key_decode = 4'h5;
      4'b01_10: key_decode = 4'h6;
      4'b01_11: key_decode = KEY_SUB;
      4'b10_00: key_decode = 4'h7;
      4'b10_01: key_decode = 4'h8;
      4'b10_10: key_decode = 4'h9;
      4'b10_11: key_decode = KEY_MUL;
      4'b11_00: key_decode = KEY_CLR;
      4'b11_01: key_decode = 4'h0;
      4'b11_10: key_decode = KEY_EQ;
      default:  key_decode = KEY_DIV;
    endcase
  endfunction

  logic [3:0]    rs;
  logic [1:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cap_q, cap_d;
  logic [3:0]    code_q, code_d, dec_code;
  logic          op_q, op_d;
  logic          eq_q, eq_d;
  logic          clr_q, clr_d;
  logic          pressed_q, pressed_d;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (reset),
    .d_i (kp.row_in),
    .q_o (rs)
  );

  assign dec_code = key_decode(cap_q, col_q);
  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    code_d    = code_q;
    op_d      = op_q;
    eq_d      = eq_q;
    clr_d     = clr_q;
    pressed_d = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rs != 4'hF) begin
            // Keep the column driven so the debouncer sees the same key.
            cap_d   = rs;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (rs != cap_q) begin
          cnt_d   = '0;
          col_d   = col_q + 1'b1;
          dwell_d = '0;
          state_d = ST_SCAN;
        end else if (cnt_q == CNT_LAST) begin
          // This sample is the DEBOUNCE_CNT-th consecutive match.
          cnt_d     = '0;
          pressed_d = 1'b1;
          code_d    = dec_code;
          op_d      = (dec_code == KEY_ADD) || (dec_code == KEY_SUB) ||
                      (dec_code == KEY_MUL) || (dec_code == KEY_DIV);
          eq_d      = (dec_code == KEY_EQ);
          clr_d     = (dec_code == KEY_CLR);
          state_d   = ST_HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        // Counts consecutive fully released samples; any low row restarts.
        if (rs != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          col_d   = col_q + 1'b1;
          dwell_d = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        dwell_d = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cap_q     <= 4'hF;
      code_q    <= 4'h0;
      op_q      <= 1'b0;
      eq_q      <= 1'b0;
      clr_q     <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      code_q    <= code_d;
      op_q      <= op_d;
      eq_q      <= eq_d;
      clr_q     <= clr_d;
      pressed_q <= pressed_d;
    end
  end

  assign kp.col_out     = ~(4'b0001 << col_q);
  assign kp.key_pressed = pressed_q;
  assign kp.key_code    = code_q;
  assign kp.is_op       = op_q;
  assign kp.is_eq       = eq_q;
  assign kp.is_clr      = clr_q;
  assign kp.dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8).
// A keypad model turns pressed keys into row levels from the driven column.
// A reference model predicts every output per cycle; directed scenarios add
// hand-computed expectations for the event list, latency and column timing.
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int SD = 4;
  localparam int DC = 8;
  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  // ---------------- keypad physics ----------------
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c closed

  function automatic logic [3:0] rows_seen(input logic [15:0] k, input logic [3:0] col_n);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !col_n[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    return ~(4'(1) << c);
  endfunction

  assign kp.row_in = rows_seen(keys, kp.col_out);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t state=%0d)", name, act, exp, $time, kp.dbg_state);
    end
  endtask

  // ---------------- reference model ----------------
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
  int m_mode, m_col, m_dwell, m_run, m_rel;
  int cyc = 0;
  int cap_cycle = 0;
  logic [3:0] m_s1, m_s2, m_cap;
  logic       exp_pressed, exp_op, exp_eq, exp_clr;
  logic [3:0] exp_code;

  task automatic model_reset();
    m_mode = M_SCAN; m_col = 0; m_dwell = 0; m_run = 0; m_rel = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_cap = 4'hF;
    exp_pressed = 1'b0; exp_code = 4'h0;
    exp_op = 1'b0; exp_eq = 1'b0; exp_clr = 1'b0;
  endtask

  task automatic model_emit();
    int row;
    int code;
    row = 0;
    while (row < 3 && m_cap[row]) row++;
    code = keymap[row*4 + m_col];
    exp_pressed = 1'b1;
    exp_code    = 4'(code);
    exp_op      = (code >= 10 && code <= 13);
    exp_eq      = (code == 14);
    exp_clr     = (code == 15);
    exp_q.push_back(4'(code));
  endtask

  task automatic model_step();
    logic [3:0] rs;
    cyc++;
    rs   = m_s2;          // value synchronized two edges ago
    m_s2 = m_s1;
    m_s1 = rows_seen(keys, col_pat(m_col));
    exp_pressed = 1'b0;
    case (m_mode)
      M_SCAN: begin
        m_dwell++;
        if (m_dwell == SD) begin
          m_dwell = 0;
          if (rs != 4'hF) begin
            m_cap = rs; m_run = 0; m_mode = M_CONFIRM;
            cap_cycle = cyc - 1;   // cycle in which the captured sample was taken
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end
      M_CONFIRM: begin
        if (rs == m_cap) begin
          m_run++;
          if (m_run == DC) begin
            model_emit();
            m_mode = M_HELD; m_rel = 0;
          end
        end else begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
        end
      end
      default: begin
        if (rs == 4'hF) begin
          m_rel++;
          if (m_rel == DC) begin
            m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end else begin
          m_rel = 0;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("col_out",     kp.col_out,     col_pat(m_col));
      check("col_onehot",  $countones(~kp.col_out), 1);
      check("key_pressed", kp.key_pressed, exp_pressed);
      check("key_code",    kp.key_code,    exp_code);
      check("is_op",       kp.is_op,       exp_op);
      check("is_eq",       kp.is_eq,       exp_eq);
      check("is_clr",      kp.is_clr,      exp_clr);
      if (kp.key_pressed) begin
        got_q.push_back(kp.key_code);
        check("latency", cyc - cap_cycle, DC + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic release_all();
    keys = '0;
  endtask

  // codes: first event in [3:0], second in [7:4]
  task automatic check_events(input string name, input int n, input logic [7:0] codes);
    check({name, "_count"}, got_q.size(), n);
    check({name, "_model_count"}, exp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check({name, "_code"}, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(codes[i*4 +: 4]));
      check({name, "_model_code"}, (i < exp_q.size()) ? int'(exp_q[i]) : -1, int'(codes[i*4 +: 4]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [3:0] idle_seq [4];
    int waited;
    idle_seq = '{4'hE, 4'hD, 4'hB, 4'h7};

    tick(3);
    check("rst_col",  kp.col_out, 4'b1110);
    check("rst_code", kp.key_code, 0);
    check("rst_strb", kp.key_pressed, 0);
    reset = 1'b0;

    // Idle: columns rotate every SD clocks, no events.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i % 4 == 0) check("idle_col", kp.col_out, idle_seq[i/4]);
    end
    check("idle_flags", {kp.is_op, kp.is_eq, kp.is_clr}, 0);
    check_events("idle", 0, 8'h00);

    // Single held digit '6'; outputs hold after release.
    press(1, 2); tick(100); release_all(); tick(40);
    check_events("six", 1, 8'h06);
    check("six_hold_code", kp.key_code, 6);
    check("six_hold_flags", {kp.is_op, kp.is_eq, kp.is_clr}, 0);

    // '=' then '+'.
    press(3, 2); tick(40); release_all(); tick(40);
    check("eq_code", kp.key_code, 14);
    check("eq_flag", {kp.is_op, kp.is_eq, kp.is_clr}, 3'b010);
    press(0, 3); tick(40); release_all(); tick(40);
    check_events("eq_add", 2, 8'hAE);
    check("add_flag", {kp.is_op, kp.is_eq, kp.is_clr}, 3'b100);

    // Bouncing '7', then held steady long enough to cover a full scan rotation.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) press(2, 0); else release_all();
      tick(3);
    end
    press(2, 0); tick(40); release_all(); tick(40);
    check_events("bounce7", 1, 8'h07);

    // Release bounce on '5'.
    press(1, 1);
    waited = 0;
    while (got_q.size() == 0 && waited < 60) begin
      tick(1);
      waited++;
    end
    check("five_accept", got_q.size(), 1);
    tick(5);
    check("five_held_col", kp.col_out, 4'b1101);
    release_all(); tick(3);
    press(1, 1); tick(5);
    release_all();
    tick(9);
    check("five_col_before", kp.col_out, 4'b1101);
    tick(1);
    check("five_col_after", kp.col_out, 4'b1011);
    tick(20);
    check_events("five", 1, 8'h05);

    // Reset four cycles into debounce of 'C', then normal detection.
    press(3, 0);
    waited = 0;
    while (m_mode != M_CONFIRM && waited < 40) begin
      tick(1);
      waited++;
    end
    check("clr_capture_wait", int'(m_mode == M_CONFIRM), 1);
    tick(4);
    reset = 1'b1;
    tick(2);
    check("abort_col",  kp.col_out, 4'b1110);
    check("abort_code", kp.key_code, 0);
    check("abort_clr",  kp.is_clr, 0);
    check_events("abort", 0, 8'h00);
    reset = 1'b0;
    tick(40); release_all(); tick(30);
    check_events("clr", 1, 8'h0F);
    check("clr_code", kp.key_code, 15);
    check("clr_flag", {kp.is_op, kp.is_eq, kp.is_clr}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the scenarios above take well under this bound.
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
